// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: Avalon-MM slave driving NUM_DIGITS seven-segment digits.
//
// Each digit shows either a hex-decoded nibble or raw segments, can blink from
// an internal prescaler, and all digits can be blanked at once. out_port is
// registered and follows register/phase state with one cycle of delay.
//
// Optional feature macro: HEX_DISPLAY_SETCLR_EN
//   When defined, address 12 sets and address 13 clears bits of the BLINK mask.
//   When undefined, these addresses behave as unused.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   address      word address
//   chipselect   slave select
//   write_n      active-low write strobe, qualified by chipselect
//   writedata    write data
//   readdata     read data, combinational from address (latency 0)
//   out_port     segments gfedcba, digit k at bits [7k+6:7k]
//   blink_phase  current blink phase
//
// Register map:
//   0..7  DIGIT[k] [6:0]       8  DECODE [NUM_DIGITS-1:0]
//   9     BLINK    mask        10 BLINK_DIV [DIV_W-1:0]
//   11    CTRL: bit0 BLANK_ALL, bit1 blink_phase (read-only)
//   12/13 BLINK_SET / BLINK_CLR (optional)
module hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned ACTIVE_LOW = 1,
  parameter int unsigned DIV_W      = 26,
  parameter int unsigned DIV_RESET  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] out_port,
  output logic                    blink_phase
);

  localparam logic [3:0] AddrDecode   = 4'd8;
  localparam logic [3:0] AddrBlink    = 4'd9;
  localparam logic [3:0] AddrDiv      = 4'd10;
  localparam logic [3:0] AddrCtrl     = 4'd11;
`ifdef HEX_DISPLAY_SETCLR_EN
  localparam logic [3:0] AddrBlinkSet = 4'd12;
  localparam logic [3:0] AddrBlinkClr = 4'd13;
`endif

  // XOR mask applied to lit segments as the very last step.
  localparam logic [6:0] InvMask = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [6:0]            digit_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] decode_q;
  logic [NUM_DIGITS-1:0] blink_q;
  logic [DIV_W-1:0]      div_q;
  logic                  blank_q;
  logic [DIV_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [7*NUM_DIGITS-1:0] out_q, out_d;

  logic wr_en;
  logic div_wr;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign div_wr       = wr_en && (address == AddrDiv);
  assign unused_wdata = ^writedata;

  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0111111;
      4'h1:    s = 7'b0000110;
      4'h2:    s = 7'b1011011;
      4'h3:    s = 7'b1001111;
      4'h4:    s = 7'b1100110;
      4'h5:    s = 7'b1101101;
      4'h6:    s = 7'b1111101;
      4'h7:    s = 7'b0000111;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1101111;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b1111100;
      4'hC:    s = 7'b0111001;
      4'hD:    s = 7'b1011110;
      4'hE:    s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    return s;
  endfunction

  // Register file writes. Reset wins over any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        digit_q[k] <= '0;
      end
      decode_q <= '0;
      blink_q  <= '0;
      div_q    <= DIV_W'(DIV_RESET);
      blank_q  <= 1'b0;
    end else if (wr_en) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (address == 4'(k)) begin
          digit_q[k] <= writedata[6:0];
        end
      end
      case (address)
        AddrDecode:   decode_q <= writedata[NUM_DIGITS-1:0];
        AddrBlink:    blink_q  <= writedata[NUM_DIGITS-1:0];
        AddrDiv:      div_q    <= writedata[DIV_W-1:0];
        AddrCtrl:     blank_q  <= writedata[0];
`ifdef HEX_DISPLAY_SETCLR_EN
        AddrBlinkSet: blink_q  <= blink_q | writedata[NUM_DIGITS-1:0];
        AddrBlinkClr: blink_q  <= blink_q & ~writedata[NUM_DIGITS-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Prescaler: a BLINK_DIV write restarts the count so a smaller divisor can
  // never leave the counter stranded above its wrap point.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (div_wr || (div_q == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == div_q - DIV_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Segment pipeline stage: decode/raw select, blanking, then polarity.
  always_comb begin
    out_d = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      logic [6:0] seg;
      seg = decode_q[k] ? hex_seg(digit_q[k][3:0]) : digit_q[k];
      if (blank_q || (blink_q[k] && phase_q)) begin
        seg = 7'h00;
      end
      out_d[7*k +: 7] = seg ^ InvMask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      out_q   <= {NUM_DIGITS{InvMask}};
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      out_q   <= out_d;
    end
  end

  // Readback returns stored values, never the driven segments.
  always_comb begin
    readdata = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (address == 4'(k)) begin
        readdata[6:0] = digit_q[k];
      end
    end
    case (address)
      AddrDecode: readdata[NUM_DIGITS-1:0] = decode_q;
      AddrBlink:  readdata[NUM_DIGITS-1:0] = blink_q;
      AddrDiv:    readdata[DIV_W-1:0]      = div_q;
      AddrCtrl:   readdata[1:0]            = {phase_q, blank_q};
      default: ;
    endcase
  end

  assign out_port    = out_q;
  assign blink_phase = phase_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  localparam int ND = 6;
  localparam int DW = 26;
  localparam int DR = 25000000;
  localparam logic [41:0] AllOff = 42'h3FF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [41:0] out_port;
  logic        blink_phase;

  hex_display_ctrl #(
    .NUM_DIGITS(ND),
    .ACTIVE_LOW(1),
    .DIV_W(DW),
    .DIV_RESET(DR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: register contents plus number of edges since the last
  // prescaler restart; blink phase is derived arithmetically from that.
  logic [6:0]  hex_tab [16] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                                7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  logic [6:0]  m_digit [ND];
  logic [5:0]  m_decode;
  logic [5:0]  m_blink;
  logic [25:0] m_div;
  logic        m_blank;
  int unsigned m_n;
  logic [41:0] m_out;

  function automatic logic m_phase();
    if (m_div == '0) return 1'b0;
    return ((m_n / 32'(m_div)) % 2) == 1;
  endfunction

  function automatic logic [41:0] m_render();
    logic [41:0] r;
    logic [6:0]  seg;
    r = '0;
    for (int k = 0; k < ND; k++) begin
      seg = m_decode[k] ? hex_tab[m_digit[k][3:0]] : m_digit[k];
      if (m_blank || (m_blink[k] && m_phase())) seg = 7'h00;
      r[7*k +: 7] = ~seg;
    end
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    if (a < ND) r[6:0] = m_digit[a];
    else if (a == 8) r[5:0] = m_decode;
    else if (a == 9) r[5:0] = m_blink;
    else if (a == 10) r[25:0] = m_div;
    else if (a == 11) r[1:0] = {m_phase(), m_blank};
    return r;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < ND; k++) m_digit[k] = '0;
    m_decode = '0;
    m_blink  = '0;
    m_div    = 26'(DR);
    m_blank  = 1'b0;
    m_n      = 0;
    m_out    = AllOff;
  endtask

  task automatic m_write(input logic [3:0] a, input logic [31:0] d);
    if (a < ND) m_digit[a] = d[6:0];
    case (a)
      4'd8:  m_decode = d[5:0];
      4'd9:  m_blink = d[5:0];
      4'd10: begin m_div = d[25:0]; m_n = 0; end
      4'd11: m_blank = d[0];
`ifdef HEX_DISPLAY_SETCLR_EN
      4'd12: m_blink = m_blink | d[5:0];
      4'd13: m_blink = m_blink & ~d[5:0];
`endif
      default: ;
    endcase
  endtask

  // One clock: drive, advance the model, sample #1 after the edge, compare.
  task automatic step(input logic cs, input logic wn, input logic [3:0] a,
                      input logic [31:0] d, input logic rst);
    logic [41:0] nxt;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    reset      = rst;
    nxt = m_render();
    @(posedge clk);
    #1;
    if (rst) begin
      m_reset();
    end else begin
      m_n++;
      if (cs && !wn) m_write(a, d);
      m_out = nxt;
    end
    check_eq("out_port", 64'(out_port), 64'(m_out));
    check_eq("blink_phase", 64'(blink_phase), 64'(m_phase()));
    check_eq("readdata", 64'(readdata), 64'(m_read(a)));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    step(1'b1, 1'b1, a, 32'h0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 4'd0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [3:0]  ra;
    logic [31:0] rdat;
    int          r;

    m_reset();
    step(1'b0, 1'b1, 4'd0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 4'd0, 32'h0, 1'b1);

    // Reset state
    rd(4'd10);
    check_eq("reset_div", 64'(readdata), 64'(32'd25000000));
    check_eq("reset_out", 64'(out_port), 64'(AllOff));

    // Hex decode
    wr(4'd8, 32'h3F);
    wr(4'd0, 32'hA);
    wr(4'd1, 32'h3);
    rd(4'd0);
    check_eq("hex_d0", 64'(out_port[6:0]), 64'(7'b1110111 ^ 7'h7F));
    check_eq("hex_d1", 64'(out_port[13:7]), 64'(7'b1001111 ^ 7'h7F));
    check_eq("read_d0", 64'(readdata), 64'(32'hA));

    // Blink toggle with divisor 4
    wr(4'd8, 32'h0);
    wr(4'd0, 32'h7F);
    wr(4'd1, 32'h06);
    wr(4'd9, 32'h01);
    wr(4'd10, 32'd4);
    for (int i = 1; i <= 12; i++) begin
      idle(1);
      if (i == 4) check_eq("phase_c4", 64'(blink_phase), 64'(1'b1));
      if (i == 5) check_eq("d0_off", 64'(out_port[6:0]), 64'(7'h7F));
      if (i == 8) check_eq("phase_c8", 64'(blink_phase), 64'(1'b0));
      if (i == 9) check_eq("d0_lit", 64'(out_port[6:0]), 64'(7'h00));
      if (i == 12) check_eq("phase_c12", 64'(blink_phase), 64'(1'b1));
      check_eq("d1_steady", 64'(out_port[13:7]), 64'(7'h06 ^ 7'h7F));
    end

    // Blink disable, then reload mid-phase-1
    wr(4'd10, 32'd0);
    idle(8);
    check_eq("div0_hold", 64'(blink_phase), 64'(1'b0));
    wr(4'd10, 32'd4);
    idle(5);
    check_eq("phase1_pre", 64'(blink_phase), 64'(1'b1));
    wr(4'd10, 32'd3);
    check_eq("reload_clr", 64'(blink_phase), 64'(1'b0));
    idle(2);
    check_eq("reload_c2", 64'(blink_phase), 64'(1'b0));
    idle(1);
    check_eq("reload_c3", 64'(blink_phase), 64'(1'b1));

    // Global blank
    wr(4'd11, 32'h1);
    idle(1);
    check_eq("blank_all", 64'(out_port), 64'(AllOff));
    wr(4'd11, 32'h0);

    // Out-of-range digit address
    wr(4'd7, 32'h55);
    rd(4'd7);
    check_eq("oor_read", 64'(readdata), 64'(32'h0));

    // Blink set/clear
    wr(4'd9, 32'h05);
    wr(4'd12, 32'h02);
    rd(4'd9);
`ifdef HEX_DISPLAY_SETCLR_EN
    check_eq("blink_set", 64'(readdata), 64'(32'h07));
`else
    check_eq("blink_set", 64'(readdata), 64'(32'h05));
`endif
    wr(4'd13, 32'h04);
    rd(4'd9);
`ifdef HEX_DISPLAY_SETCLR_EN
    check_eq("blink_clr", 64'(readdata), 64'(32'h03));
`else
    check_eq("blink_clr", 64'(readdata), 64'(32'h05));
`endif

    // Reset during blinking, with a concurrent write
    wr(4'd10, 32'd2);
    wr(4'd9, 32'h3F);
    idle(3);
    step(1'b1, 1'b0, 4'd10, 32'd1, 1'b1);
    check_eq("rst_div", 64'(readdata), 64'(32'd25000000));
    check_eq("rst_phase", 64'(blink_phase), 64'(1'b0));
    check_eq("rst_out", 64'(out_port), 64'(AllOff));
    idle(1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r    = int'($urandom % 4);
      ra   = 4'($urandom % 16);
      rdat = $urandom;
      if (ra == 4'd10) rdat = $urandom_range(0, 6);
      if (ra == 4'd11) rdat = 32'(($urandom % 4) == 0);
      step(r != 0, r != 1, ra, rdat, ($urandom % 128) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
